// File: rtl/lector_memoria_imagen.sv
// Image memory reader: issues pipelined Avalon-style reads for one configured image
// and steers the returned words into a rotating set of line buffers.
module lector_memoria_imagen #(
    parameter int BITS_BUS_DATOS_INSTR = 21,
    parameter int BITS_BUFFERS_IMAGEN  = 2,
    parameter int BITS_DATOS_MEM       = 32,
    parameter int INCREMENTO_DIRECCION = 4,
    parameter int MAX_PENDIENTES       = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [BITS_BUS_DATOS_INSTR-1:0]       direccion_mem_inicio_imagen,
    input  logic [BITS_BUS_DATOS_INSTR-1:0]       cantidad_lecturas_mem,
    input  logic [BITS_BUFFERS_IMAGEN-1:0]        cantidad_buffers_internos,
    input  logic [BITS_BUS_DATOS_INSTR-1:0]       palabras_por_linea,
    input  logic                                  iniciar,
    input  logic                                  pausa,
    output logic [BITS_BUS_DATOS_INSTR-1:0]       mem_direccion,
    output logic                                  mem_lectura,
    input  logic                                  mem_espera,
    input  logic [BITS_DATOS_MEM-1:0]             mem_datos,
    input  logic                                  mem_datos_validos,
    output logic [BITS_DATOS_MEM-1:0]             datos_buffer,
    output logic [(1<<BITS_BUFFERS_IMAGEN)-1:0]   escritura_buffer,
    output logic                                  ocupado,
    output logic                                  terminado
);

    localparam int W           = BITS_BUS_DATOS_INSTR;
    localparam int BITS_PEND   = $clog2(MAX_PENDIENTES) + 1;
    localparam int NUM_BUFFERS = 1 << BITS_BUFFERS_IMAGEN;
    localparam logic [BITS_PEND-1:0] MAX_PEND = BITS_PEND'(MAX_PENDIENTES);
    localparam logic [W-1:0]         UNO      = W'(1);
    localparam logic [W-1:0]         PASO     = W'(INCREMENTO_DIRECCION);

    typedef enum logic [1:0] {REPOSO, LEYENDO, DRENANDO, TERMINADO} estado_t;

    estado_t                        estado_q;
    logic [W-1:0]                   direccion_q;
    logic [W-1:0]                   total_q;
    logic [W-1:0]                   palabras_linea_q;
    logic [W-1:0]                   emitidas_q;
    logic [W-1:0]                   palabra_q;
    logic [BITS_BUFFERS_IMAGEN-1:0] ultimo_buffer_q;
    logic [BITS_BUFFERS_IMAGEN-1:0] selector_q;
    logic [BITS_PEND-1:0]           pendientes_q;
    logic [BITS_PEND-1:0]           pendientes_d;
    logic                           sostener_q;
    logic [BITS_DATOS_MEM-1:0]      datos_q;
    logic [NUM_BUFFERS-1:0]         escritura_q;
    logic                           lectura;
    logic                           aceptada;
    logic                           dato_valido;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        lectura = 1'b0;
        // A stalled request stays up regardless of pausa until memory takes it.
        if (estado_q == LEYENDO)
            lectura = sostener_q ||
                      ((emitidas_q < total_q) && (pendientes_q < MAX_PEND) && !pausa);
        aceptada    = lectura && !mem_espera;
        dato_valido = mem_datos_validos && (pendientes_q != '0) &&
                      ((estado_q == LEYENDO) || (estado_q == DRENANDO));
        pendientes_d = pendientes_q;
        if (aceptada && !dato_valido)
            pendientes_d = pendientes_q + BITS_PEND'(1);
        else if (!aceptada && dato_valido)
            pendientes_d = pendientes_q - BITS_PEND'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            estado_q         <= REPOSO;
            direccion_q      <= '0;
            total_q          <= '0;
            palabras_linea_q <= '0;
            emitidas_q       <= '0;
            palabra_q        <= '0;
            ultimo_buffer_q  <= '0;
            selector_q       <= '0;
            pendientes_q     <= '0;
            sostener_q       <= 1'b0;
            datos_q          <= '0;
            escritura_q      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            escritura_q  <= '0;
            sostener_q   <= lectura && mem_espera;
            pendientes_q <= pendientes_d;

            if (aceptada) begin
                direccion_q <= direccion_q + PASO;
                emitidas_q  <= emitidas_q + UNO;
            end

            if (dato_valido) begin
                datos_q     <= mem_datos;
                escritura_q <= NUM_BUFFERS'(1) << selector_q;
                if (palabra_q == palabras_linea_q - UNO) begin
                    palabra_q  <= '0;
                    selector_q <= (selector_q == ultimo_buffer_q) ? '0
                                : selector_q + BITS_BUFFERS_IMAGEN'(1);
                end else begin
                    palabra_q <= palabra_q + UNO;
                end
            end

            case (estado_q)
                REPOSO: begin
                    if (iniciar) begin
                        direccion_q      <= direccion_mem_inicio_imagen;
                        total_q          <= cantidad_lecturas_mem;
                        palabras_linea_q <= palabras_por_linea;
                        ultimo_buffer_q  <= cantidad_buffers_internos;
                        emitidas_q       <= '0;
                        pendientes_q     <= '0;
                        palabra_q        <= '0;
                        selector_q       <= '0;
                        estado_q         <= (cantidad_lecturas_mem == '0) ? TERMINADO : LEYENDO;
                    end
                end
                LEYENDO: begin
                    if (aceptada && (emitidas_q + UNO == total_q))
                        estado_q <= DRENANDO;
                end
                // Leaving on the edge that retires the last word puts its write in TERMINADO.
                DRENANDO: begin
                    if (pendientes_d == '0)
                        estado_q <= TERMINADO;
                end
                TERMINADO: estado_q <= REPOSO;
                default:   estado_q <= REPOSO;
            endcase
        end
    end

    assign mem_direccion    = direccion_q;
    assign mem_lectura      = lectura;
    assign datos_buffer     = datos_q;
    assign escritura_buffer = escritura_q;
    assign ocupado          = (estado_q == LEYENDO) || (estado_q == DRENANDO);
    assign terminado        = (estado_q == TERMINADO);

endmodule

// File: tb/tb_lector_memoria_imagen.sv
// Randomized self-checking bench for lector_memoria_imagen: a queue-based memory
// model answers reads, and expected addresses/buffer writes follow from the job config.
module tb_lector_memoria_imagen;

    localparam int W    = 21;
    localparam int BB   = 2;
    localparam int D    = 32;
    localparam int INC  = 4;
    localparam int MAXP = 8;
    localparam int NB   = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  dir_inicio;
    logic [W-1:0]  cantidad;
    logic [W-1:0]  palabras;
    logic [BB-1:0] buffers;
    logic          iniciar;
    logic          pausa = 1'b0;
    logic [W-1:0]  mem_direccion;
    logic          mem_lectura;
    logic          mem_espera = 1'b0;
    logic [D-1:0]  mem_datos = '0;
    logic          mem_datos_validos = 1'b0;
    logic [D-1:0]  datos_buffer;
    logic [NB-1:0] escritura_buffer;
    logic          ocupado;
    logic          terminado;

    always #5 clk = ~clk;

    lector_memoria_imagen dut (
        .clk                         (clk),
        .reset                       (reset),
        .direccion_mem_inicio_imagen (dir_inicio),
        .cantidad_lecturas_mem       (cantidad),
        .cantidad_buffers_internos   (buffers),
        .palabras_por_linea          (palabras),
        .iniciar                     (iniciar),
        .pausa                       (pausa),
        .mem_direccion               (mem_direccion),
        .mem_lectura                 (mem_lectura),
        .mem_espera                  (mem_espera),
        .mem_datos                   (mem_datos),
        .mem_datos_validos           (mem_datos_validos),
        .datos_buffer                (datos_buffer),
        .escritura_buffer            (escritura_buffer),
        .ocupado                     (ocupado),
        .terminado                   (terminado)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stimulus-owned knobs
    int           job_gen = 0;
    logic [W-1:0] cfg_start = '0;
    int           cfg_ppl = 1;
    int           cfg_nbuf = 0;
    bit           hold_data = 1'b0;
    int           espera_mode = 0;
    int           stall_idx = 0;
    int           stall_len = 0;
    int           block_after = 0;
    int           lat_min = 1;
    int           lat_max = 1;
    bit           pausa_forzada = 1'b0;
    bit           pausa_rand = 1'b0;

    // Model-owned state
    typedef struct { int ready; logic [D-1:0] data; } resp_t;
    resp_t        resp_q[$];
    logic [D-1:0] exp_data_q[$];
    int           cyc = 0;
    int           seen_gen = 0;
    logic [W-1:0] exp_start = '0;
    int           exp_ppl = 1;
    int           exp_nbuf = 0;
    int           job_acc = 0, job_ret = 0, job_wr = 0, job_term = 0, job_lect = 0;
    int           job_stalls = 0, job_pause_acc = 0, job_max_pend = 0, stall_given = 0;
    int           wr_total = 0, term_total = 0;
    bit           prev_stall = 1'b0;
    logic [W-1:0] prev_dir = '0;
    logic [W-1:0] ea;
    logic [NB-1:0] oh;
    logic [D-1:0] dv;
    resp_t        r;
    int           idx, pend;

    always begin
        @(posedge clk);
        #1;
        cyc++;
        case (espera_mode)
            0: mem_espera = 1'b0;
            1: mem_espera = ($urandom_range(0, 3) == 0);
            2: begin
                mem_espera = (job_acc == stall_idx) && (stall_given < stall_len);
                if (mem_espera) stall_given++;
            end
            default: mem_espera = (job_acc >= block_after);
        endcase
        pausa = pausa_forzada || (pausa_rand && ($urandom_range(0, 4) == 0));
        if (!hold_data && resp_q.size() > 0 && resp_q[0].ready <= cyc) begin
            mem_datos_validos = 1'b1;
            mem_datos         = resp_q[0].data;
            void'(resp_q.pop_front());
        end else begin
            mem_datos_validos = 1'b0;
            mem_datos         = $urandom;
        end

        @(negedge clk);
        if (job_gen != seen_gen) begin
            seen_gen = job_gen;
            exp_start = cfg_start; exp_ppl = cfg_ppl; exp_nbuf = cfg_nbuf;
            job_acc = 0; job_ret = 0; job_wr = 0; job_term = 0; job_lect = 0;
            job_stalls = 0; job_pause_acc = 0; job_max_pend = 0; stall_given = 0;
        end
        if (reset == 1'b0) begin
            exp_data_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_lectura", 64'(mem_lectura), 64'(1));
                check("hold_direccion", 64'(mem_direccion), 64'(prev_dir));
            end
            if (mem_lectura) job_lect++;
            if (mem_lectura && mem_espera) job_stalls++;
            if (mem_lectura && !mem_espera) begin
                ea = exp_start + W'(INC * job_acc);
                check("direccion", 64'(mem_direccion), 64'(ea));
                if (pausa && !prev_stall) job_pause_acc++;
                dv = $urandom;
                r.ready = cyc + $urandom_range(lat_min, lat_max);
                r.data  = dv;
                resp_q.push_back(r);
                exp_data_q.push_back(dv);
                job_acc++;
            end
            if (mem_datos_validos) job_ret++;
            pend = job_acc - job_ret;
            if (pend > job_max_pend) job_max_pend = pend;
            if (escritura_buffer != '0) begin
                wr_total++;
                if (exp_data_q.size() == 0) begin
                    check("escritura_extra", 64'(escritura_buffer), 64'(0));
                end else begin
                    idx = (job_wr / exp_ppl) % (exp_nbuf + 1);
                    oh  = NB'(1) << idx;
                    check("escritura_sel", 64'(escritura_buffer), 64'(oh));
                    check("datos_buffer", 64'(datos_buffer), 64'(exp_data_q.pop_front()));
                    job_wr++;
                end
            end
            if (terminado) begin
                job_term++;
                term_total++;
                check("wr_at_done", 64'(job_wr), 64'(job_acc));
            end
            prev_stall = mem_lectura && mem_espera;
            prev_dir   = mem_direccion;
        end
    end

    task automatic drv_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic start_job(input logic [W-1:0] s, input int n, input int ppl, input int nb);
        drv_cycle();
        cfg_start = s; cfg_ppl = ppl; cfg_nbuf = nb;
        job_gen++;
        dir_inicio = s; cantidad = W'(n); palabras = W'(ppl); buffers = BB'(nb);
        iniciar = 1'b1;
        drv_cycle();
        iniciar    = 1'b0;
        dir_inicio = W'($urandom);
        cantidad   = W'($urandom_range(0, 5));
        palabras   = W'($urandom_range(1, 7));
        buffers    = BB'($urandom);
    endtask

    task automatic finish_job(input int n, input int budget);
        int waited = 0;
        while (job_term == 0 && waited < budget) begin
            chk_cycle();
            waited++;
        end
        check("done_in_time", 64'(job_term != 0), 64'(1));
        repeat (4) chk_cycle();
        check("acceptances", 64'(job_acc), 64'(n));
        check("writes", 64'(job_wr), 64'(n));
        check("terminado_pulses", 64'(job_term), 64'(1));
        check("idle_after", 64'(ocupado), 64'(0));
        check("pend_le_max", 64'(job_max_pend <= MAXP), 64'(1));
    endtask

    task automatic wait_acc(input int target, input int budget);
        int waited = 0;
        while (job_acc < target && waited < budget) begin
            chk_cycle();
            waited++;
        end
        check("reach_acceptances", 64'(job_acc), 64'(target));
    endtask

    initial begin
        #600000;
        $display("FAIL global_timeout: run did not finish, %0d tests run", tests_run);
        $fatal(1, "global timeout");
    end

    initial begin
        int wr_before, term_before, n;
        logic [W-1:0] s;

        reset = 1'b0; iniciar = 1'b0;
        dir_inicio = '0; cantidad = '0; palabras = W'(1); buffers = '0;
        repeat (3) drv_cycle();
        check("rst_ocupado", 64'(ocupado), 64'(0));
        check("rst_lectura", 64'(mem_lectura), 64'(0));
        check("rst_terminado", 64'(terminado), 64'(0));
        check("rst_escritura", 64'(escritura_buffer), 64'(0));
        check("rst_direccion", 64'(mem_direccion), 64'(0));
        check("rst_datos", 64'(datos_buffer), 64'(0));
        reset = 1'b1;

        // Basic stream: fixed 2-cycle latency, three buffers of two words.
        lat_min = 2; lat_max = 2;
        start_job(W'('h100), 6, 2, 2);
        finish_job(6, 200);
        check("t2_next_dir", 64'(mem_direccion), 64'('h118));

        // Waitrequest held for 3 cycles on the second request.
        espera_mode = 2; stall_idx = 1; stall_len = 3;
        start_job(W'('h100), 6, 2, 2);
        finish_job(6, 200);
        check("t3_stall_cycles", 64'(job_stalls), 64'(3));
        espera_mode = 0;

        // Outstanding-read limit with data withheld.
        hold_data = 1'b1; lat_min = 1; lat_max = 3;
        start_job(W'('h2000), 12, 4, 3);
        wait_acc(8, 40);
        repeat (5) chk_cycle();
        check("t4_acc_capped", 64'(job_acc), 64'(8));
        check("t4_lectura_low", 64'(mem_lectura), 64'(0));
        hold_data = 1'b0;
        chk_cycle();
        check("t4_low_on_first_valid", 64'(mem_lectura), 64'(0));
        chk_cycle();
        check("t4_resume", 64'(mem_lectura), 64'(1));
        finish_job(12, 400);
        check("t4_max_pend", 64'(job_max_pend), 64'(8));

        // Zero-length job.
        start_job(W'('h40), 0, 1, 0);
        check("t5_term_next", 64'(terminado), 64'(1));
        finish_job(0, 20);
        check("t5_no_lectura", 64'(job_lect), 64'(0));

        // Pause mid-stream, single buffer, stray start while busy.
        lat_min = 1; lat_max = 2;
        start_job(W'('h300), 10, 3, 0);
        repeat (2) drv_cycle();
        pausa_forzada = 1'b1;
        drv_cycle();
        iniciar = 1'b1;
        drv_cycle();
        iniciar = 1'b0;
        repeat (3) drv_cycle();
        pausa_forzada = 1'b0;
        finish_job(10, 300);
        check("t6_no_acc_in_pause", 64'(job_pause_acc), 64'(0));

        // Reset with three reads in flight; late data must be dropped.
        hold_data = 1'b1; espera_mode = 3; block_after = 3;
        start_job(W'('h500), 12, 2, 1);
        wait_acc(3, 40);
        repeat (2) chk_cycle();
        check("t1_lectura_held", 64'(mem_lectura), 64'(1));
        wr_before = wr_total; term_before = term_total;
        drv_cycle();
        reset = 1'b0;
        drv_cycle();
        reset = 1'b1;
        check("t1_ocupado", 64'(ocupado), 64'(0));
        check("t1_lectura", 64'(mem_lectura), 64'(0));
        check("t1_escritura", 64'(escritura_buffer), 64'(0));
        espera_mode = 0; hold_data = 1'b0;
        repeat (10) chk_cycle();
        check("t1_no_late_writes", 64'(wr_total), 64'(wr_before));
        check("t1_no_terminado", 64'(term_total), 64'(term_before));
        check("t1_still_idle", 64'(ocupado), 64'(0));

        // Randomized jobs with random waitrequest, latency and pause.
        espera_mode = 1; pausa_rand = 1'b1; lat_min = 1; lat_max = 4;
        for (int j = 0; j < 8; j++) begin
            if (j == 0) begin
                s = W'('h1FFFF8);
                n = 5;
            end else begin
                s = W'($urandom) & ~W'(3);
                n = $urandom_range(1, 20);
            end
            start_job(s, n, $urandom_range(1, 5), $urandom_range(0, 3));
            finish_job(n, 1500);
        end
        pausa_rand = 1'b0; espera_mode = 0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
